wb32_to_wb8_bridge: RTL

//  Width bridge between the 32-bit CPU Wishbone master and the 8-bit peripheral bus
//  (GPIO and other byte-wide slaves). Splits each 32-bit access into one 8-bit access
//  per set select bit, in ascending lane order, and assembles read bytes into a word.

---
 rtl/wb32_to_wb8_bridge_if.sv | 38 +++
 rtl/wb32_to_wb8_bridge.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/wb32_to_wb8_bridge_if.sv
// -----------------------------------------------------------------------------
// wb32_to_wb8_bridge_if
// Bus bundle for the 32-bit to 8-bit Wishbone width bridge. It carries both the
// upstream (32-bit CPU side) and downstream (8-bit peripheral side) signals.
//   slave  modport : the bridge's view (I_* inputs, O_* outputs)
//   master modport : the environment's view (CPU master + byte-wide slave)
// Upstream  : I_wb_stb, I_wb_we, I_wb_adr, I_wb_sel, I_wb_dat, O_wb_ack, O_wb_err,
//             O_wb_dat
// Downstream: O_wb8_stb, O_wb8_we, O_wb8_adr, O_wb8_dat, I_wb8_ack, I_wb8_dat
// -----------------------------------------------------------------------------
interface wb32_to_wb8_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  I_wb_stb;
   logic                  I_wb_we;
   logic [ADDR_WIDTH-1:0] I_wb_adr;
   logic [3:0]            I_wb_sel;
   logic [31:0]           I_wb_dat;
   logic                  O_wb_ack;
   logic                  O_wb_err;
   logic [31:0]           O_wb_dat;
   logic                  O_wb8_stb;
   logic                  O_wb8_we;
   logic [ADDR_WIDTH-1:0] O_wb8_adr;
   logic [7:0]            O_wb8_dat;
   logic                  I_wb8_ack;
   logic [7:0]            I_wb8_dat;

   modport slave (
      input  I_wb_stb, I_wb_we, I_wb_adr, I_wb_sel, I_wb_dat, I_wb8_ack, I_wb8_dat,
      output O_wb_ack, O_wb_err, O_wb_dat, O_wb8_stb, O_wb8_we, O_wb8_adr, O_wb8_dat
   );

   modport master (
      output I_wb_stb, I_wb_we, I_wb_adr, I_wb_sel, I_wb_dat, I_wb8_ack, I_wb8_dat,
      input  O_wb_ack, O_wb_err, O_wb_dat, O_wb8_stb, O_wb8_we, O_wb8_adr, O_wb8_dat
   );
endinterface

// File: rtl/wb32_to_wb8_bridge.sv
// -----------------------------------------------------------------------------
// wb32_to_wb8_bridge
// Splits each 32-bit Wishbone access into one byte access per set select bit, in
// ascending lane order, and assembles read bytes into a word. A per-lane ack timeout
// (TIMEOUT_CYCLES, 0 = disabled) stops a dead slave from hanging the CPU; a timed-out
// lane reads 8'hFF and flags O_wb_err alongside O_wb_ack.
// Ports:
//   I_wb_clk  in  single clock for both sides
//   I_reset   in  asynchronous active-high reset
//   io_bus    bus upstream/downstream signals (slave modport of wb32_to_wb8_bridge_if)
// -----------------------------------------------------------------------------
module wb32_to_wb8_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                 I_wb_clk,
   input logic                 I_reset,
   wb32_to_wb8_bridge_if.slave io_bus
);
   // Counter only has to hold 0..TIMEOUT_CYCLES-1: the lane is abandoned on the cycle
   // the count would reach TIMEOUT_CYCLES.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {StIdle, StIssue, StGap, StDone, StRecover} state_e;

   state_e                r_state, w_state_d;
   logic [ADDR_WIDTH-3:0] r_adr_hi;
   logic [3:0]            r_sel;
   logic [31:0]           r_wdat;
   logic                  r_we;
   logic [31:0]           r_rdat, w_rdat_d;
   logic                  r_err, w_err_d;
   logic [1:0]            r_lane, w_lane_d;
   logic [CNT_W-1:0]      r_cnt, w_cnt_d;
   logic                  r_wb8_stb;
   logic                  r_ack;
   logic                  r_ack_err;
   logic                  w_accept;
   logic                  w_first_vld, w_next_vld;
   logic [1:0]            w_first_lane, w_next_lane;
   logic                  w_unused_adr;

   assign w_unused_adr = ^io_bus.I_wb_adr[1:0];

   // Lowest set select bit of the incoming access.
   always_comb begin
      w_first_vld  = 1'b0;
      w_first_lane = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (io_bus.I_wb_sel[i]) begin
            w_first_vld  = 1'b1;
            w_first_lane = 2'(i);
         end
      end
   end

   // Lowest captured select bit above the current lane.
   always_comb begin
      w_next_vld  = 1'b0;
      w_next_lane = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r_sel[i] && (i > int'(r_lane))) begin
            w_next_vld  = 1'b1;
            w_next_lane = 2'(i);
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_lane_d  = r_lane;
      w_cnt_d   = r_cnt;
      w_rdat_d  = r_rdat;
      w_err_d   = r_err;
      w_accept  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (io_bus.I_wb_stb) begin
               w_accept = 1'b1;
               w_rdat_d = '0;
               w_err_d  = 1'b0;
               w_cnt_d  = '0;
               if (w_first_vld) begin
                  w_state_d = StIssue;
                  w_lane_d  = w_first_lane;
               end else begin
                  w_state_d = StDone;
               end
            end
         end
         StIssue: begin
            w_cnt_d = r_cnt + 1'b1;
            if (io_bus.I_wb8_ack) begin
               if (!r_we) w_rdat_d[{r_lane, 3'b000} +: 8] = io_bus.I_wb8_dat;
               w_state_d = StGap;
            end else if (TO_EN && (r_cnt == CNT_LAST)) begin
               w_err_d = 1'b1;
               if (!r_we) w_rdat_d[{r_lane, 3'b000} +: 8] = 8'hFF;
               w_state_d = StGap;
            end
         end
         StGap: begin
            // Any ack seen here is the trailing ack of the previous lane.
            if (w_next_vld) begin
               w_state_d = StIssue;
               w_lane_d  = w_next_lane;
               w_cnt_d   = '0;
            end else begin
               w_state_d = StDone;
            end
         end
         StDone:    w_state_d = StRecover;
         StRecover: w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge I_wb_clk or posedge I_reset) begin
      if (I_reset) begin
         r_state   <= StIdle;
         r_adr_hi  <= '0;
         r_sel     <= '0;
         r_wdat    <= '0;
         r_we      <= 1'b0;
         r_rdat    <= '0;
         r_err     <= 1'b0;
         r_lane    <= '0;
         r_cnt     <= '0;
         r_wb8_stb <= 1'b0;
         r_ack     <= 1'b0;
         r_ack_err <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_rdat    <= w_rdat_d;
         r_err     <= w_err_d;
         r_lane    <= w_lane_d;
         r_cnt     <= w_cnt_d;
         r_wb8_stb <= (w_state_d == StIssue);
         r_ack     <= (w_state_d == StDone);
         r_ack_err <= (w_state_d == StDone) && w_err_d;
         if (w_accept) begin
            r_adr_hi <= io_bus.I_wb_adr[ADDR_WIDTH-1:2];
            r_sel    <= io_bus.I_wb_sel;
            r_wdat   <= io_bus.I_wb_dat;
            r_we     <= io_bus.I_wb_we;
         end
      end
   end

   // Downstream qualifiers are zero whenever no byte access is in flight.
   assign io_bus.O_wb8_stb = r_wb8_stb;
   assign io_bus.O_wb8_we  = r_wb8_stb & r_we;
   assign io_bus.O_wb8_adr = r_wb8_stb ? {r_adr_hi, r_lane} : '0;
   assign io_bus.O_wb8_dat = r_wb8_stb ? r_wdat[{r_lane, 3'b000} +: 8] : 8'h00;
   assign io_bus.O_wb_ack  = r_ack;
   assign io_bus.O_wb_err  = r_ack_err;
   assign io_bus.O_wb_dat  = r_rdat;
endmodule
